// File: rtl/tdm_slot_sequencer_pkg.sv
// tdm_pkg: shared constants and types for the TDM slot sequencer.
//   NUM_CH      - number of requesters / mux channels
//   SEL_W       - width of the binary channel select
//   tdm_state_e - sequencer states (GUARD encoded even when not built)
//   S_*         - state constants used by the state register
//   ch_idx_t    - binary channel index
package tdm_pkg;

    localparam int unsigned NUM_CH = 4;
    localparam int unsigned SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GUARD  = 2'd2
    } tdm_state_e;

    // Plain constants for the state register, matching the enum encoding.
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_ACTIVE = ACTIVE;
    localparam logic [1:0] S_GUARD  = GUARD;

    typedef logic [SEL_W-1:0] ch_idx_t;

endpackage

// File: rtl/tdm_slot_sequencer_if.sv
// tdm_slot_sequencer_if: request / select bundle between the sequencer and
// the mux/demux datapath.
//   req          - per-channel request level (bit i = channel i)
//   select_lines - binary index of the granted channel
//   grant        - one-hot grant, zero when no slot is active
//   sel_valid    - high while a slot is active
//   slot_done    - one-cycle pulse after a slot ends
// Modports: master = sequencer side, slave = requester/datapath side.
interface tdm_slot_sequencer_if;
    import tdm_pkg::*;

    logic [NUM_CH-1:0] req;
    ch_idx_t           select_lines;
    logic [NUM_CH-1:0] grant;
    logic              sel_valid;
    logic              slot_done;

    modport master (
        input  req,
        output select_lines,
        output grant,
        output sel_valid,
        output slot_done
    );

    modport slave (
        output req,
        input  select_lines,
        input  grant,
        input  sel_valid,
        input  slot_done
    );

endinterface

// File: rtl/tdm_slot_sequencer_rr_pick.sv
// rr_pick: combinational rotating-priority encoder.
//   req    - request vector
//   last   - last-served channel; search order is last+1, +2, +3, last
//   any    - at least one request is high
//   winner - first requesting channel in the search order
module rr_pick
    import tdm_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  ch_idx_t           last,
    output logic              any,
    output ch_idx_t           winner
);

    ch_idx_t w_cand;

    always_comb begin
        any    = |req;
        winner = last;
        w_cand = last;
        // Walk the order backwards so the nearest requester is written last.
        for (int i = int'(NUM_CH); i >= 1; i--) begin
            w_cand = last + ch_idx_t'(i);
            if (req[w_cand]) begin
                winner = w_cand;
            end
        end
    end

endmodule

// File: rtl/tdm_slot_sequencer.sv
// tdm_slot_sequencer: round-robin time-slot owner of the mux/demux select.
// Grants one channel at a time for at most MAX_DWELL (1..255) cycles.
// Ports:
//   clk - clock, rising edge
//   rst - synchronous active-high reset
//   bus - tdm_slot_sequencer_if.master (req in; select_lines, grant,
//         sel_valid, slot_done out)
// Build option: define TDM_GUARD_EN to insert a one-cycle dead slot between
// consecutive grants so demux outputs settle before the next channel.
module tdm_slot_sequencer
    import tdm_pkg::*;
#(
    parameter int unsigned MAX_DWELL = 8
) (
    input  logic clk,
    input  logic rst,
    tdm_slot_sequencer_if.master bus
);

    localparam logic [7:0] LP_DWELL = 8'(MAX_DWELL);

    logic [1:0] r_state, w_state_d;
    ch_idx_t    r_ch,    w_ch_d;
    ch_idx_t    r_last,  w_last_d;
    logic [7:0] r_cnt,   w_cnt_d;
    logic       r_done,  w_done_d;

    logic       w_any;
    ch_idx_t    w_winner;
    ch_idx_t    w_pick_last;
    logic       w_release;
    logic       w_valid;

    // On a release the new last-served channel is the current one, so the
    // back-to-back re-arbitration must already rotate past it.
    assign w_pick_last = (r_state == S_ACTIVE) ? r_ch : r_last;

    rr_pick u_pick (
        .req    (bus.req),
        .last   (w_pick_last),
        .any    (w_any),
        .winner (w_winner)
    );

    assign w_release = !bus.req[r_ch] || (r_cnt == LP_DWELL);

    always_comb begin
        w_state_d = r_state;
        w_ch_d    = r_ch;
        w_last_d  = r_last;
        w_cnt_d   = r_cnt;
        w_done_d  = 1'b0;
        case (r_state)
`ifdef TDM_GUARD_EN
            S_IDLE, S_GUARD: begin
`else
            S_IDLE: begin
`endif
                if (w_any) begin
                    w_state_d = S_ACTIVE;
                    w_ch_d    = w_winner;
                    w_cnt_d   = 8'd1;
                end else begin
                    w_state_d = S_IDLE;
                end
            end
            S_ACTIVE: begin
                if (w_release) begin
                    w_last_d = r_ch;
                    w_done_d = 1'b1;
`ifdef TDM_GUARD_EN
                    w_state_d = S_GUARD;
`else
                    if (w_any) begin
                        w_ch_d  = w_winner;
                        w_cnt_d = 8'd1;
                    end else begin
                        w_state_d = S_IDLE;
                    end
`endif
                end else begin
                    w_cnt_d = r_cnt + 8'd1;
                end
            end
            default: w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_ch    <= '0;
            r_last  <= ch_idx_t'(NUM_CH - 1);
            r_cnt   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_ch    <= w_ch_d;
            r_last  <= w_last_d;
            r_cnt   <= w_cnt_d;
            r_done  <= w_done_d;
        end
    end

    // Outputs decode registered state only; req never reaches them directly.
    assign w_valid          = (r_state == S_ACTIVE);
    assign bus.sel_valid    = w_valid;
    assign bus.select_lines = r_ch;
    assign bus.grant        = w_valid ? (NUM_CH'(1) << r_ch) : '0;
    assign bus.slot_done    = r_done;

endmodule

// File: tb/tb_tdm_slot_sequencer.sv
// tb_tdm_slot_sequencer: three sequencers (dwell 8, 3, 1) on shared stimulus.
// Directed vector tables plus randomized requests checked every cycle against
// a slot-level reference model.
module tb_tdm_slot_sequencer;

`ifdef TDM_GUARD_EN
    localparam bit GUARD_ON = 1'b1;
`else
    localparam bit GUARD_ON = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       tb_rst = 1'b1;
    logic [3:0] tb_req = 4'b0000;

    always #5 clk = ~clk;

    tdm_slot_sequencer_if if8 ();
    tdm_slot_sequencer_if if3 ();
    tdm_slot_sequencer_if if1 ();
    assign if8.req = tb_req;
    assign if3.req = tb_req;
    assign if1.req = tb_req;

    tdm_slot_sequencer #(.MAX_DWELL(8)) u_d8 (.clk(clk), .rst(tb_rst), .bus(if8));
    tdm_slot_sequencer #(.MAX_DWELL(3)) u_d3 (.clk(clk), .rst(tb_rst), .bus(if3));
    tdm_slot_sequencer #(.MAX_DWELL(1)) u_d1 (.clk(clk), .rst(tb_rst), .bus(if1));

    // Packed view per instance: {select_lines, grant, sel_valid, slot_done}
    logic [7:0] dut_out [3];
    assign dut_out[0] = {if8.select_lines, if8.grant, if8.sel_valid, if8.slot_done};
    assign dut_out[1] = {if3.select_lines, if3.grant, if3.sel_valid, if3.slot_done};
    assign dut_out[2] = {if1.select_lines, if1.grant, if1.sel_valid, if1.slot_done};

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    int dwell   [3] = '{8, 3, 1};
    int m_owner [3];   // -1 when no slot is active
    int m_age   [3];
    int m_last  [3];
    int m_sel   [3];
    bit m_done  [3];
    bit m_en = 1'b0;
    int m_w;

    function automatic int pick(logic [3:0] r, int last);
        for (int off = 1; off <= 4; off++) begin
            int c;
            c = (last + off) % 4;
            if (r[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [7:0] model_out(int k);
        logic [3:0] g;
        g = (m_owner[k] >= 0) ? 4'(1 << m_owner[k]) : 4'b0000;
        return {2'(m_sel[k]), g, m_owner[k] >= 0, m_done[k]};
    endfunction

    initial forever begin
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (tb_rst) begin
                m_owner[k] = -1; m_age[k] = 0; m_last[k] = 3; m_sel[k] = 0; m_done[k] = 0;
            end else if (m_owner[k] >= 0) begin
                if (!tb_req[m_owner[k]] || m_age[k] == dwell[k]) begin
                    m_last[k] = m_owner[k];
                    m_done[k] = 1'b1;
                    m_owner[k] = -1;
                    if (!GUARD_ON) begin
                        m_w = pick(tb_req, m_last[k]);
                        if (m_w >= 0) begin
                            m_owner[k] = m_w; m_age[k] = 1; m_sel[k] = m_w;
                        end
                    end
                end else begin
                    m_age[k]++;
                    m_done[k] = 1'b0;
                end
            end else begin
                m_done[k] = 1'b0;
                m_w = pick(tb_req, m_last[k]);
                if (m_w >= 0) begin
                    m_owner[k] = m_w; m_age[k] = 1; m_sel[k] = m_w;
                end
            end
        end
        if (tb_rst) m_en = 1'b1;
        #1;
        if (m_en) begin
            for (int k = 0; k < 3; k++) begin
                logic [7:0] o;
                logic [3:0] g;
                bit inv_ok;
                o = dut_out[k];
                n_tests++;
                if (o !== model_out(k)) begin
                    n_fail++;
                    $display("FAIL model inst%0d t=%0t: got sel/grant/valid/done=%b required %b",
                             k, $time, o, model_out(k));
                end
                g = o[5:2];
                inv_ok = ((g & (g - 4'd1)) == 4'd0) && ((g != 4'd0) == o[1]) &&
                         (!o[1] || g == 4'(1 << o[7:6]));
                n_tests++;
                if (!inv_ok) begin
                    n_fail++;
                    $display("FAIL invariant inst%0d t=%0t: got %b required consistent one-hot",
                             k, $time, o);
                end
            end
        end
    end

    // ---------------- directed vector table ----------------
    typedef struct {
        int         inst;
        bit         rst;
        logic [3:0] req;
        logic [1:0] sel;
        logic [3:0] grant;
        bit         valid;
        bit         done;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(int inst, bit rst, logic [3:0] req, logic [1:0] sel,
                                logic [3:0] grant, bit valid, bit done);
        vec_t v;
        v.inst = inst; v.rst = rst; v.req = req; v.sel = sel;
        v.grant = grant; v.valid = valid; v.done = done;
        vecs.push_back(v);
    endfunction

    function automatic void build_table();
        int ch;
        int prev;
        // Single request, dwell expiry, re-grant, then mid-slot reset at cnt 5.
        add(0, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 4'b0100, 2'd2, 4'b0100, 1, 0);
        add(0, 0, 4'b0100, 2'd2, GUARD_ON ? 4'b0000 : 4'b0100, !GUARD_ON, 1);
        for (int i = 0; i < (GUARD_ON ? 5 : 4); i++) add(0, 0, 4'b0100, 2'd2, 4'b0100, 1, 0);
        add(0, 1, 4'b1111, 2'd0, 4'b0000, 0, 0);
        add(0, 0, 4'b1111, 2'd0, 4'b0001, 1, 0);
        // All requesting with dwell 3: order 0,1,2,3,0.
        add(1, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        prev = 0;
        for (int s = 0; s < 5; s++) begin
            ch = s % 4;
            if (s > 0 && GUARD_ON) add(1, 0, 4'b1111, 2'(prev), 4'b0000, 0, 1);
            for (int k = 0; k < 3; k++)
                add(1, 0, 4'b1111, 2'(ch), 4'(1 << ch), 1, k == 0 && s > 0 && !GUARD_ON);
            prev = ch;
        end
        // Early release of ch 1 at cnt 2 with ch 3 waiting.
        add(0, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        add(0, 0, 4'b0010, 2'd1, 4'b0010, 1, 0);
        add(0, 0, 4'b0010, 2'd1, 4'b0010, 1, 0);
        add(0, 0, 4'b1000, GUARD_ON ? 2'd1 : 2'd3, GUARD_ON ? 4'b0000 : 4'b1000,
            !GUARD_ON, 1);
        add(0, 0, 4'b1000, 2'd3, 4'b1000, 1, 0);
        add(0, 0, 4'b1000, 2'd3, 4'b1000, 1, 0);
        // Dwell 1 with req 1010: 1,3,1,3.
        add(2, 1, 4'b0000, 2'd0, 4'b0000, 0, 0);
        prev = 1;
        for (int s = 0; s < 4; s++) begin
            ch = (s % 2 == 1) ? 3 : 1;
            if (s > 0 && GUARD_ON) add(2, 0, 4'b1010, 2'(prev), 4'b0000, 0, 1);
            add(2, 0, 4'b1010, 2'(ch), 4'(1 << ch), 1, s > 0 && !GUARD_ON);
            prev = ch;
        end
    endfunction

    initial begin
        logic [7:0] exp_o;
        logic [7:0] got;
        build_table();
        foreach (vecs[i]) begin
            @(negedge clk);
            tb_rst = vecs[i].rst;
            tb_req = vecs[i].req;
            @(posedge clk);
            #2;
            exp_o = {vecs[i].sel, vecs[i].grant, vecs[i].valid, vecs[i].done};
            got   = dut_out[vecs[i].inst];
            n_tests++;
            if (got !== exp_o) begin
                n_fail++;
                $display("FAIL vector %0d inst%0d: got sel/grant/valid/done=%b required %b",
                         i, vecs[i].inst, got, exp_o);
            end
        end
        // Randomized phase: requests tend to persist so long slots expire.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            tb_rst = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 3) == 0) tb_req = 4'($urandom);
        end
        @(negedge clk);
        tb_rst = 1'b0;
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tdm_slot_sequencer.md
# tdm_slot_sequencer

- Round-robin time-slot sequencer that owns the 2-bit channel select for the 4-to-1 data multiplexer and the 1-to-4 demultiplexer.
- Four requesters ask for the shared path. The sequencer grants one channel at a time and holds it for a bounded dwell.
- It drives `select_lines`, a one-hot grant and a valid qualifier. Downstream logic samples mux and demux data only while `sel_valid` is high.

## Interface
Parameters:
- `MAX_DWELL`, default 8: maximum consecutive grant cycles per slot. Legal range 1..255.

Ports:
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  reset, synchronous and active-high.
- `req`  input  4  per-channel request level; bit i = channel i.
- `select_lines`  output  2  binary index of the granted channel; feeds mux and demux select.
- `grant`  output  4  one-hot grant; all zero when no slot is active.
- `sel_valid`  output  1  high exactly while a slot is active.
- `slot_done`  output  1  one-cycle pulse in the cycle after a slot ends.

## Operation
- **Reset values:**
  - State IDLE.
  - `select_lines`=2'b00, `grant`=4'b0000, `sel_valid`=0, `slot_done`=0.
  - Last-served pointer `last`=3, so channel 0 has top priority first.
  - Dwell counter `cnt`=0.
- **Arbitration:** rotating priority, searching `last+1`, `last+2`, `last+3`, `last` (mod 4). The first channel with its `req` bit high wins.
- **State IDLE:**
  - Outputs are at their reset values, except `select_lines`, which holds its last value.
  - If any `req` bit is high at the edge, go to ACTIVE with `ch`=winner and `cnt`=1.
- **State ACTIVE:**
  - `grant`=1<<`ch`, `select_lines`=`ch`, `sel_valid`=1.
  - At each edge, check the release condition: `req[ch]`==0 or `cnt`==`MAX_DWELL`.
  - No release: `cnt`<=`cnt`+1.
  - Release: `last`<=`ch` and `slot_done`<=1. Then:
    - Guard compiled in: go to GUARD.
    - Guard compiled out, some `req` bit high: re-arbitrate with the new `last`, stay in ACTIVE with the new `ch` and `cnt`=1.
    - Guard compiled out, no `req` bit high: go to IDLE.
- **State GUARD (guard compiled in only):**
  - Lasts one cycle with `grant`=0 and `sel_valid`=0; `select_lines` holds.
  - At the next edge, arbitrate as in IDLE.
- **Boundary cases:**
  - Sole requester whose slot expires: it is re-granted (it is last in the rotation) and `cnt` restarts at 1.
  - A request deasserted and reasserted within the same slot is not seen as a release unless it was low at an edge.
  - `MAX_DWELL`=1: every grant lasts exactly one cycle and rotates among the active requesters.
  - `rst` asserted in any state: reset values at the next edge, regardless of `req`. The slot in progress is aborted without a `slot_done` pulse.
- **Invariants:**
  - `grant` is one-hot or zero.
  - `grant` is non-zero if and only if `sel_valid`=1.
  - `select_lines`==index of `grant` whenever `sel_valid`=1.
- **Widths:** `cnt` is 8 bits; `last` and `ch` are 2 bits with natural wrap-around.

## Timing
- All outputs are registered; there is no combinational path from `req` to any output.
- Request to grant latency is 1 cycle: `req` high at edge N gives `sel_valid`=1 after edge N.
- Slot length:
  - Dwell-limited slot: exactly `MAX_DWELL` cycles of `sel_valid`.
  - Slot ended by `req[ch]` low at edge N: `sel_valid` (or the grant to `ch`) drops after edge N.
- Back-to-back grants, guard out: the new `grant` appears on the edge after the release decision, with no gap cycle.
- Guard in: exactly one cycle of `sel_valid`=0 between consecutive slots.
- `slot_done` is high for one cycle beginning at the release edge. It coincides with the first GUARD, IDLE or new-slot cycle.

## Configuration
- Macro `TDM_GUARD_EN`:
  - Defined: the GUARD state exists and a one-cycle dead slot separates every pair of grants. The demux outputs settle before the next channel's data is qualified.
  - Undefined: GUARD is not built and channel changes are back-to-back.
- Reset behaviour, latency and arbitration order are identical in both builds.

## Structure
- Package `tdm_pkg`:
  - `NUM_CH`=4, `SEL_W`=2.
  - State enum `tdm_state_e` {IDLE, ACTIVE, GUARD}; GUARD is encoded even when unused.
  - Typedef `ch_idx_t` (logic [`SEL_W`-1:0]).
- Sub-module `rr_pick`: purely combinational rotating priority encoder.
  - Inputs: `req[3:0]` and `last`.
  - Outputs: `any` and `winner`.
  - Instanced once.

## Test plan
- **Reset then single request:**
  - Stimulus: reset, then `req`=4'b0100 held.
  - Required:
    - `sel_valid` rises 1 cycle later with `select_lines`=2 and `grant`=4'b0100.
    - With `MAX_DWELL`=8, `slot_done` pulses after 8 cycles.
    - Re-grant to ch 2: immediate (guard out) or after a 1-cycle gap (guard in).
- **All requesting:** `req`=4'b1111 with `MAX_DWELL`=3. Required grant order is 0,1,2,3,0, each slot exactly 3 cycles.
- **Early release:** ch 1 granted, `req[1]` drops at `cnt`=2 while `req[3]` is high. Required: the grant moves to ch 3 (after a gap if `TDM_GUARD_EN`), and `slot_done` pulses once.
- **Mid-slot reset:** `rst` asserted during ACTIVE with `cnt`=5.
  - Next cycle: `grant`=0, `sel_valid`=0, `select_lines`=0, no `slot_done`.
  - After reset releases with `req`=4'b1111: ch 0 is granted first.
- **`MAX_DWELL`=1 with `req`=4'b1010:** grants alternate 1,3,1,3, each 1 cycle. `slot_done` is high every cycle (guard out).
- **Invariants checked every cycle in all scenarios:** `grant` one-hot or zero, and `grant`/`select_lines`/`sel_valid` consistent.
